// File: rtl/pe_stream_loader_pkg.sv
// Shared definitions for the PE stream loader, the PE and the mesh top:
// loader state encodings and the default pad word.
package pe_stream_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PAD     = 2'd2,
        ST_COMPUTE = 2'd3
    } loader_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // All-ones pads sort after every real key.
    localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_PAD_VALUE = '1;

endpackage

// File: rtl/pe_cycle_timer.sv
// Clearable cycle counter with a terminal-count pulse; used to time the PE
// compute window and reusable for the PE's sort phases.
module pe_cycle_timer #(
    parameter int CYCLES = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] TC_VALUE = CW'(CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == TC_VALUE) ? '0 : r_count + 1'b1;
        end
    end

    assign o_tc = i_en && (r_count == TC_VALUE);

endmodule

// File: rtl/pe_stream_loader.sv
// Loads DEPTH words from a valid/ready stream into a PE's local memory
// (padding short streams), then releases the PE for a timed compute window.
module pe_stream_loader
    import pe_stream_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = 3,
    parameter int DEPTH          = 4,
    parameter int COMPUTE_CYCLES = 7,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    output logic                  o_pe_rst,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_short,
    output logic                  o_overrun
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
    localparam logic [CW-1:0] END_IDX  = CW'(DEPTH);

    loader_state_t r_state, w_next;

    logic [CW-1:0]         r_count;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_short;
    logic                  r_overrun;
    logic                  r_done;
    logic                  w_accept;
    logic                  w_tc;

    assign w_accept = s_valid && (r_state == ST_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // PAD doubles as the drain cycle for full streams, so COMPUTE always
    // starts the cycle after the last write is visible on the memory port.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (i_start) w_next = ST_LOAD;
            ST_LOAD:    if (w_accept && (s_last || r_count == LAST_IDX)) w_next = ST_PAD;
            ST_PAD:     if (r_count == END_IDX) w_next = ST_COMPUTE;
            ST_COMPUTE: if (w_tc) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_short   <= 1'b0;
            r_overrun <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= w_tc;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_count   <= '0;
                        r_short   <= 1'b0;
                        r_overrun <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_count[ADDR_WIDTH-1:0];
                        r_data  <= s_data;
                        r_count <= r_count + 1'b1;
                        if (r_count == LAST_IDX && !s_last) r_overrun <= 1'b1;
                        if (r_count != LAST_IDX && s_last)  r_short   <= 1'b1;
                    end
                end
                ST_PAD: begin
                    if (r_count != END_IDX) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_count[ADDR_WIDTH-1:0];
                        r_data  <= PAD_VALUE;
                        r_count <= r_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pe_cycle_timer #(
        .CYCLES (COMPUTE_CYCLES)
    ) u_compute_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (r_state != ST_COMPUTE),
        .i_en    (r_state == ST_COMPUTE),
        .o_tc    (w_tc)
    );

    assign s_ready    = (r_state == ST_LOAD);
    assign o_mem_we   = r_we;
    assign o_mem_addr = r_addr;
    assign o_mem_data = r_data;
    assign o_pe_rst   = (r_state != ST_COMPUTE);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = r_done;
    assign o_short    = r_short;
    assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_pe_stream_loader.sv
// Directed self-checking bench for pe_stream_loader (DEPTH=4, COMPUTE_CYCLES=7).
module tb_pe_stream_loader;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 4;
    localparam int CC    = 7;
    localparam logic [DW-1:0] PAD = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_data;
    logic          o_pe_rst;
    logic          o_busy;
    logic          o_done;
    logic          o_short;
    logic          o_overrun;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] mem [0:7];
    int writeCount = 0;
    int doneCount = 0;
    int peLowCount = 0;
    int highAddrWrites = 0;
    int cyc = 0;
    int addrLog [$];

    pe_stream_loader #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .DEPTH          (DEPTH),
        .COMPUTE_CYCLES (CC),
        .PAD_VALUE      (PAD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_data (o_mem_data),
        .o_pe_rst   (o_pe_rst),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_short    (o_short),
        .o_overrun  (o_overrun)
    );

    always #5 clk = ~clk;

    // Memory model and event counters seen from the PE side of the loader.
    always @(posedge clk) begin
        cyc++;
        if (o_mem_we === 1'b1) begin
            mem[o_mem_addr] = o_mem_data;
            writeCount++;
            addrLog.push_back(int'(o_mem_addr));
            if (int'(o_mem_addr) >= DEPTH) highAddrWrites++;
        end
        if (o_done === 1'b1) doneCount++;
        if (o_pe_rst === 1'b0) peLowCount++;
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic valid,
                                 input logic [DW-1:0] data, input logic last);
        i_start = start;
        s_valid = valid;
        s_data  = data;
        s_last  = last;
        @(negedge clk);
    endtask

    task automatic waitDone(input string tag, output int doneCyc);
        int k;
        k = 0;
        while (o_done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        doneCyc = cyc;
        if (o_done !== 1'b1) checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic checkImage(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                              input logic [DW-1:0] e2, input logic [DW-1:0] e3);
        checkOutput({tag, "_mem0"}, mem[0], e0);
        checkOutput({tag, "_mem1"}, mem[1], e1);
        checkOutput({tag, "_mem2"}, mem[2], e2);
        checkOutput({tag, "_mem3"}, mem[3], e3);
    endtask

    initial begin
        int wc0, dc0, pl0, log0, firstCyc, doneCyc;
        logic [DW-1:0] fullBeats [4];
        logic [DW-1:0] ovBeats [6];
        fullBeats = '{32'd9, 32'd3, 32'd7, 32'd1};
        ovBeats   = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_s_ready",  32'(s_ready),    32'd0);
        checkOutput("rst_mem_we",   32'(o_mem_we),   32'd0);
        checkOutput("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        checkOutput("rst_mem_data", o_mem_data,      32'd0);
        checkOutput("rst_pe_rst",   32'(o_pe_rst),   32'd1);
        checkOutput("rst_busy",     32'(o_busy),     32'd0);
        checkOutput("rst_done",     32'(o_done),     32'd0);
        checkOutput("rst_short",    32'(o_short),    32'd0);
        checkOutput("rst_overrun",  32'(o_overrun),  32'd0);
        checkOutput("rst_writes",   32'(writeCount), 32'd0);

        // Full stream at full rate
        wc0 = writeCount; dc0 = doneCount; pl0 = peLowCount; log0 = addrLog.size();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("full_ready", 32'(s_ready), 32'd1);
        checkOutput("full_busy",  32'(o_busy),  32'd1);
        firstCyc = cyc;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, fullBeats[i], i == 3);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        waitDone("full", doneCyc);
        checkOutput("full_latency", 32'(doneCyc - firstCyc), 32'(DEPTH + CC + 1));
        checkOutput("full_pe_rst_after", 32'(o_pe_rst), 32'd1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkImage("full", 32'd9, 32'd3, 32'd7, 32'd1);
        checkOutput("full_writes",   32'(writeCount - wc0), 32'd4);
        checkOutput("full_done_cnt", 32'(doneCount - dc0),  32'd1);
        checkOutput("full_pe_low",   32'(peLowCount - pl0), 32'(CC));
        checkOutput("full_short",    32'(o_short),          32'd0);
        checkOutput("full_overrun",  32'(o_overrun),        32'd0);
        checkOutput("full_busy_end", 32'(o_busy),           32'd0);
        for (int k = 0; k < 4; k++) checkOutput("full_addr_seq", 32'(addrLog[log0 + k]), 32'(k));

        // Short stream gets padded
        wc0 = writeCount;
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd5, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd2, 1'b1);
        checkOutput("short_ready_pad", 32'(s_ready), 32'd0);
        checkOutput("short_busy_pad",  32'(o_busy),  32'd1);
        s_valid = 1'b0; s_last = 1'b0;
        waitDone("short", doneCyc);
        checkImage("short", 32'd5, 32'd2, PAD, PAD);
        checkOutput("short_writes",  32'(writeCount - wc0), 32'd4);
        checkOutput("short_flag",    32'(o_short),          32'd1);
        checkOutput("short_overrun", 32'(o_overrun),        32'd0);

        // Backpressure: valid toggles every cycle
        wc0 = writeCount; log0 = addrLog.size();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("bp_short_cleared", 32'(o_short), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, fullBeats[i], i == 3);
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
        end
        waitDone("bp", doneCyc);
        checkImage("bp", 32'd9, 32'd3, 32'd7, 32'd1);
        checkOutput("bp_writes", 32'(writeCount - wc0), 32'd4);
        for (int k = 0; k < 4; k++) checkOutput("bp_addr_seq", 32'(addrLog[log0 + k]), 32'(k));

        // Overrun: six beats, no last
        wc0 = writeCount;
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checkOutput("ov_ready", 32'(s_ready), (i < 4) ? 32'd1 : 32'd0);
            applyStimulus(1'b0, 1'b1, ovBeats[i], 1'b0);
        end
        s_valid = 1'b0;
        waitDone("ov", doneCyc);
        checkImage("ov", 32'd11, 32'd12, 32'd13, 32'd14);
        checkOutput("ov_writes", 32'(writeCount - wc0), 32'd4);
        checkOutput("ov_flag",   32'(o_overrun),        32'd1);
        checkOutput("ov_short",  32'(o_short),          32'd0);

        // Reset in the middle of a load, then reload
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("mid_overrun_cleared", 32'(o_overrun), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'd31, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd32, 1'b0);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_we",   32'(o_mem_we), 32'd0);
        checkOutput("mid_busy", 32'(o_busy),   32'd0);
        wc0 = writeCount;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'd99, 1'b0);
        s_valid = 1'b0;
        checkOutput("mid_no_writes", 32'(writeCount - wc0), 32'd0);
        log0 = addrLog.size();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 32'(21 + i), i == 3);
        s_valid = 1'b0; s_last = 1'b0;
        waitDone("reload", doneCyc);
        checkImage("reload", 32'd21, 32'd22, 32'd23, 32'd24);
        checkOutput("reload_first_addr", 32'(addrLog[log0]),        32'd0);
        checkOutput("reload_writes",     32'(addrLog.size() - log0), 32'd4);
        checkOutput("high_addr_writes",  32'(highAddrWrites),       32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
